// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared ALU opcodes, sequencer state encoding and datapath width
package mac_pkg;

    localparam int MAC_W = 16;

    localparam logic [2:0] ALU_NOP = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_MUL = 3'd3;
    localparam logic [2:0] ALU_DEC = 3'd4;
    localparam logic [2:0] ALU_CLR = 3'd5;
    localparam logic [2:0] ALU_XOR = 3'd6;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CLR   = 4'd1,
        ST_CLR_W = 4'd2,
        ST_FETCH = 4'd3,
        ST_MUL   = 4'd4,
        ST_MUL_W = 4'd5,
        ST_ADD   = 4'd6,
        ST_ADD_W = 4'd7,
        ST_DONE  = 4'd8
    } mac_state_e;

endpackage

// File: rtl/mac_sequencer_if.sv
// rtl/mac_sequencer_if.sv - job, operand, ALU and result signals of the sequencer (MAC_SAT_EN adds sat_flag)
interface mac_sequencer_if #(
    parameter int W     = 16,
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             opnd_valid;
    logic             opnd_ready;
    logic [W-1:0]     opnd_a;
    logic [W-1:0]     opnd_b;
    logic [2:0]       alu_op;
    logic [W-1:0]     alu_in1;
    logic [W-1:0]     alu_in2;
    logic [W-1:0]     alu_out;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_data;
`ifdef MAC_SAT_EN
    logic             sat_flag;
`endif

    // master is the sequencer itself; slave is the fetch logic, ALU and result consumer
    modport master (
        input  start, len, opnd_valid, opnd_a, opnd_b, alu_out, res_ready,
        output busy, opnd_ready, alu_op, alu_in1, alu_in2, res_valid, res_data
`ifdef MAC_SAT_EN
        , output sat_flag
`endif
    );

    modport slave (
        output start, len, opnd_valid, opnd_a, opnd_b, alu_out, res_ready,
        input  busy, opnd_ready, alu_op, alu_in1, alu_in2, res_valid, res_data
`ifdef MAC_SAT_EN
        , input sat_flag
`endif
    );

endinterface

// File: rtl/mac_lat_cnt.sv
// rtl/mac_lat_cnt.sv - ALU latency wait counter shared by the CLR_W/MUL_W/ADD_W states
module mac_lat_cnt #(
    parameter int ALU_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic last
);
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    logic [CW-1:0] cnt;

    assign last = run && (cnt == CW'(ALU_LAT - 1));

    // wait states are never adjacent, so clearing whenever idle restarts each wait cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - sequences a shared ALU through one dot product; MAC_SAT_EN selects saturating sum
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int W       = MAC_W,
    parameter int LEN_W   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    mac_sequencer_if.master bus
);
    localparam logic [3:0] S_IDLE  = 4'(ST_IDLE);
    localparam logic [3:0] S_CLR   = 4'(ST_CLR);
    localparam logic [3:0] S_CLR_W = 4'(ST_CLR_W);
    localparam logic [3:0] S_FETCH = 4'(ST_FETCH);
    localparam logic [3:0] S_MUL   = 4'(ST_MUL);
    localparam logic [3:0] S_MUL_W = 4'(ST_MUL_W);
    localparam logic [3:0] S_ADD   = 4'(ST_ADD);
    localparam logic [3:0] S_ADD_W = 4'(ST_ADD_W);
    localparam logic [3:0] S_DONE  = 4'(ST_DONE);

    logic [3:0]       state, state_n;
    logic [W-1:0]     acc, acc_n;
    logic [W-1:0]     prod, prod_n;
    logic [LEN_W-1:0] cnt;
    logic             lat_run, lat_last;
`ifdef MAC_SAT_EN
    logic             sat_q, sat_n;
`endif

    assign lat_run = (state == S_CLR_W) || (state == S_MUL_W) || (state == S_ADD_W);

    mac_lat_cnt #(.ALU_LAT(ALU_LAT)) u_lat (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (lat_run),
        .last (lat_last)
    );

    always_comb begin
        state_n = state;
        acc_n   = acc;
        prod_n  = prod;
`ifdef MAC_SAT_EN
        sat_n   = sat_q;
`endif
        case (state)
            S_IDLE: if (bus.start) state_n = S_CLR;
            S_CLR: begin
                state_n = S_CLR_W;
`ifdef MAC_SAT_EN
                sat_n   = 1'b0;
`endif
            end
            S_CLR_W: if (lat_last) begin
                acc_n   = '0;
                state_n = (cnt == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: if (bus.opnd_valid && bus.opnd_ready) state_n = S_MUL;
            S_MUL:   state_n = S_MUL_W;
            S_MUL_W: if (lat_last) begin
                prod_n  = bus.alu_out;
                state_n = S_ADD;
            end
            S_ADD:   state_n = S_ADD_W;
            S_ADD_W: if (lat_last) begin
`ifdef MAC_SAT_EN
                // an unsigned sum smaller than its accumulator input means the add carried out
                if (sat_q || (bus.alu_out < acc)) begin
                    acc_n = '1;
                    sat_n = 1'b1;
                end else begin
                    acc_n = bus.alu_out;
                end
`else
                acc_n   = bus.alu_out;
`endif
                state_n = (cnt == LEN_W'(1)) ? S_DONE : S_FETCH;
            end
            S_DONE:  if (bus.res_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // outputs are decoded from the next state so every port comes straight from a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            acc            <= '0;
            prod           <= '0;
            cnt            <= '0;
            bus.busy       <= 1'b0;
            bus.opnd_ready <= 1'b0;
            bus.alu_op     <= ALU_NOP;
            bus.alu_in1    <= '0;
            bus.alu_in2    <= '0;
            bus.res_valid  <= 1'b0;
            bus.res_data   <= '0;
`ifdef MAC_SAT_EN
            sat_q          <= 1'b0;
            bus.sat_flag   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            acc   <= acc_n;
            prod  <= prod_n;

            if (state == S_IDLE && bus.start) begin
                cnt <= bus.len;
            end else if (state == S_ADD_W && lat_last) begin
                cnt <= cnt - 1'b1;
            end

            bus.busy       <= (state_n != S_IDLE);
            bus.opnd_ready <= (state_n == S_FETCH);
            bus.res_valid  <= (state_n == S_DONE);
            if (state_n == S_DONE && state != S_DONE) begin
                bus.res_data <= acc_n;
            end

            bus.alu_op <= ALU_NOP;
            case (state_n)
                S_CLR: bus.alu_op <= ALU_CLR;
                S_MUL: begin
                    bus.alu_op  <= ALU_MUL;
                    bus.alu_in1 <= bus.opnd_a;
                    bus.alu_in2 <= bus.opnd_b;
                end
                S_ADD: begin
                    bus.alu_op  <= ALU_ADD;
                    bus.alu_in1 <= acc_n;
                    bus.alu_in2 <= prod_n;
                end
                default: ;
            endcase
`ifdef MAC_SAT_EN
            sat_q        <= sat_n;
            bus.sat_flag <= (state_n == S_DONE) && sat_n;
`endif
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - table-driven bench for mac_sequencer with a behavioural ALU (honours MAC_SAT_EN)
module tb_mac_sequencer;
    import mac_pkg::*;

    localparam int W     = 16;
    localparam int LEN_W = 8;

    typedef struct {
        int                  len;
        logic [3:0][W-1:0]   a;
        logic [3:0][W-1:0]   b;
        logic [W-1:0]        exp_wrap;
        logic [W-1:0]        exp_sat;
        logic                exp_flag;
        int                  gap;
        int                  hold;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_sequencer_if #(.W(W), .LEN_W(LEN_W)) bus ();

    mac_sequencer #(.W(W), .LEN_W(LEN_W), .ALU_LAT(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ALU evaluates whenever the opcode changes; result is visible one cycle later
    logic [2:0]   alu_prev = 3'd0;
    logic [W-1:0] alu_q = '0;
    assign bus.alu_out = alu_q;
    always @(posedge clk) begin
        alu_prev <= bus.alu_op;
        if (bus.alu_op != alu_prev) begin
            case (bus.alu_op)
                ALU_MUL: alu_q <= bus.alu_in1 * bus.alu_in2;
                ALU_ADD: alu_q <= bus.alu_in1 + bus.alu_in2;
                ALU_CLR: alu_q <= '0;
                default: ;
            endcase
        end
    end

    int ready_cnt = 0;
    int bad_op_cnt = 0;
    always @(negedge clk) begin
        if (bus.opnd_ready) ready_cnt <= ready_cnt + 1;
        if (bus.alu_op == 3'd2 || bus.alu_op == 3'd4 || bus.alu_op == 3'd6 || bus.alu_op == 3'd7)
            bad_op_cnt <= bad_op_cnt + 1;
    end

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[7];

    task automatic check(input logic [31:0] act, input logic [31:0] exp, input string nm);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check(32'(bus.busy),       0, {tag, " busy"});
        check(32'(bus.opnd_ready), 0, {tag, " opnd_ready"});
        check(32'(bus.res_valid),  0, {tag, " res_valid"});
        check(32'(bus.res_data),   0, {tag, " res_data"});
        check(32'(bus.alu_op),     0, {tag, " alu_op"});
        check(32'(bus.alu_in1),    0, {tag, " alu_in1"});
        check(32'(bus.alu_in2),    0, {tag, " alu_in2"});
`ifdef MAC_SAT_EN
        check(32'(bus.sat_flag),   0, {tag, " sat_flag"});
`endif
    endtask

    function automatic vec_t mk(input int len,
                                input logic [W-1:0] a0, b0, a1, b1, a2, b2, a3, b3,
                                input logic [W-1:0] ew, es, input logic ef,
                                input int gap, hold);
        vec_t v;
        v.len = len;
        v.a[0] = a0; v.b[0] = b0; v.a[1] = a1; v.b[1] = b1;
        v.a[2] = a2; v.b[2] = b2; v.a[3] = a3; v.b[3] = b3;
        v.exp_wrap = ew; v.exp_sat = es; v.exp_flag = ef;
        v.gap = gap; v.hold = hold;
        return v;
    endfunction

    // abort>0: assert reset asynchronously while the abort-th ADD is on the ALU
    task automatic run_job(input vec_t v, input string tag, input int abort);
        int idx, gap_left, cyc, drops, adds;
        logic [W-1:0] exp;
`ifdef MAC_SAT_EN
        exp = v.exp_sat;
`else
        exp = v.exp_wrap;
`endif
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = LEN_W'(v.len);
        @(negedge clk);
        bus.start = 1'b0;
        check(32'(bus.busy), 1, {tag, " busy after start"});
        idx = 0; gap_left = v.gap; cyc = 0; drops = 0; adds = 0;
        while (!bus.res_valid && cyc < 2000) begin
            if (bus.opnd_valid) begin
                bus.opnd_valid = 1'b0;
                idx++;
                gap_left = v.gap;
            end
            if (gap_left < v.gap && !bus.opnd_ready) drops++;
            if (abort > 0 && bus.alu_op == ALU_ADD) begin
                adds++;
                if (adds == abort) begin
                    rst_n = 1'b0;
                    #1;
                    check_reset({tag, " async"});
                    bus.opnd_valid = 1'b0;
                    @(negedge clk);
                    check_reset({tag, " held"});
                    rst_n = 1'b1;
                    return;
                end
            end
            if (bus.opnd_ready) begin
                if (gap_left > 0) begin
                    gap_left--;
                    if (gap_left == 5) bus.start = 1'b1;
                end else if (idx < 4) begin
                    bus.opnd_valid = 1'b1;
                    bus.opnd_a     = v.a[idx];
                    bus.opnd_b     = v.b[idx];
                end
            end
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end
        check(32'(bus.res_valid), 1, {tag, " res_valid (timeout)"});
        check(32'(bus.res_data), 32'(exp), {tag, " res_data"});
        check(32'(idx), 32'(v.len), {tag, " operand handshakes"});
        check(32'(drops), 0, {tag, " opnd_ready dropped while stalled"});
`ifdef MAC_SAT_EN
        check(32'(bus.sat_flag), 32'(v.exp_flag), {tag, " sat_flag"});
`endif
        for (int i = 0; i < v.hold; i++) begin
            bus.start = (i == 1);
            @(negedge clk);
            check(32'(bus.res_valid), 1, {tag, " res_valid held"});
            check(32'(bus.res_data), 32'(exp), {tag, " res_data held"});
        end
        bus.start     = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check(32'(bus.res_valid), 0, {tag, " res_valid after accept"});
        check(32'(bus.busy), 0, {tag, " busy after accept"});
        @(negedge clk);
        check(32'(bus.busy), 0, {tag, " stays idle"});
        check(32'(bus.alu_op), 0, {tag, " no stray CLR"});
    endtask

    initial begin
        int rc0;
        vecs[0] = mk(3, 1, 2, 3, 4, 5, 6, 0, 0, 16'd44, 16'd44, 1'b0, 0, 0);
        vecs[1] = mk(2, 16'hFFFF, 16'hFFFF, 2, 3, 0, 0, 0, 0, 16'h0007, 16'h0007, 1'b0, 0, 0);
        vecs[2] = mk(2, 16'hFFFF, 1, 2, 3, 0, 0, 0, 0, 16'h0005, 16'hFFFF, 1'b1, 0, 0);
        vecs[3] = mk(1, 16'h0100, 16'h0100, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1'b0, 0, 0);
        vecs[4] = mk(4, 10, 20, 30, 40, 7, 9, 1000, 3, 16'h116F, 16'h116F, 1'b0, 0, 0);
        vecs[5] = mk(2, 7, 8, 9, 10, 0, 0, 0, 0, 16'h0092, 16'h0092, 1'b0, 10, 0);
        vecs[6] = mk(1, 16'h1234, 1, 0, 0, 0, 0, 0, 0, 16'h1234, 16'h1234, 1'b0, 0, 5);

        bus.start = 1'b0; bus.len = '0; bus.opnd_valid = 1'b0;
        bus.opnd_a = '0; bus.opnd_b = '0; bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_job(vecs[i], $sformatf("vec%0d", i), 0);

        rc0 = ready_cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.len = '0;
        @(negedge clk);
        bus.start = 1'b0;
        check(32'(bus.alu_op), 32'(ALU_CLR), "len0 CLR issued");
        @(negedge clk);
        check(32'(bus.res_valid), 0, "len0 not done at cycle 2");
        @(negedge clk);
        check(32'(bus.res_valid), 1, "len0 done at cycle 3");
        check(32'(bus.res_data), 0, "len0 res_data");
        check(32'(ready_cnt - rc0), 0, "len0 opnd_ready never high");
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check(32'(bus.busy), 0, "len0 busy after accept");

        run_job(vecs[4], "abort", 2);
        run_job(vecs[4], "after_abort", 0);

        check(32'(bad_op_cnt), 0, "illegal alu_op issued");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
